coerencia_snoop_n: RTL

Clocked snooping cache-coherence controller for a private cache of `NUM_LINHAS` lines. Holds a per-line MSI state table, or MESI when compiled in, and serialises processor requests onto a shared bus with a valid/ack handshake. Snoops bus traffic from other caches every cycle and signals write-backs. Sits between the cache datapath and the shared coherence bus, one instance per core.

---
 rtl/coerencia_pkg.sv | 31 +++
 rtl/transicao_emissor.sv | 69 ++++++
 rtl/coerencia_snoop_n.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/coerencia_pkg.sv
// Shared encodings for the snooping coherence controller: line states, bus messages,
// processor ops and the controller FSM states.
package coerencia_pkg;

   typedef enum logic [1:0] {
      LINHA_I = 2'b00,
      LINHA_M = 2'b01,
      LINHA_S = 2'b10,
      LINHA_E = 2'b11
   } linha_t;

   typedef enum logic [1:0] {
      MSG_INVALIDAR  = 2'b00,
      MSG_READ_MISS  = 2'b01,
      MSG_WRITE_MISS = 2'b10,
      MSG_SEM        = 2'b11
   } msg_t;

   typedef enum logic [1:0] {
      OP_READ_HIT   = 2'b00,
      OP_READ_MISS  = 2'b01,
      OP_WRITE_HIT  = 2'b10,
      OP_WRITE_MISS = 2'b11
   } op_t;

   typedef enum logic {
      OCIOSO     = 1'b0,
      ESPERA_BUS = 1'b1
   } fsm_t;

endpackage

// File: rtl/transicao_emissor.sv
// Processor-side coherence function: (line state, op, shared) -> (new state, bus msg,
// writeBack, erro). COERENCIA_MESI_EN adds the E state.
module transicao_emissor
   import coerencia_pkg::*;
(
   input  linha_t estado_i,
   input  op_t    op_i,
   input  logic   compartilhado_i,
   output linha_t novo_o,
   output msg_t   msg_o,
   output logic   wb_o,
   output logic   erro_o
);

   linha_t ler_novo;

`ifdef COERENCIA_MESI_EN
   assign ler_novo = compartilhado_i ? LINHA_S : LINHA_E;
`else
   logic compartilhado_unused;
   assign compartilhado_unused = compartilhado_i;
   assign ler_novo = LINHA_S;
`endif

   always_comb begin
      novo_o = estado_i;
      msg_o  = MSG_SEM;
      wb_o   = 1'b0;
      erro_o = 1'b0;
      case (estado_i)
         LINHA_I: begin
            case (op_i)
               OP_READ_MISS:  begin novo_o = ler_novo; msg_o = MSG_READ_MISS; end
               OP_WRITE_MISS: begin novo_o = LINHA_M; msg_o = MSG_WRITE_MISS; end
               OP_WRITE_HIT:  erro_o = 1'b1;
               default: ;
            endcase
         end
         LINHA_M: begin
            case (op_i)
               OP_READ_MISS:  begin novo_o = LINHA_S; msg_o = MSG_READ_MISS; wb_o = 1'b1; end
               OP_WRITE_MISS: begin novo_o = LINHA_M; msg_o = MSG_WRITE_MISS; wb_o = 1'b1; end
               default: ;
            endcase
         end
         LINHA_S: begin
            case (op_i)
               OP_READ_MISS:  begin novo_o = LINHA_S; msg_o = MSG_READ_MISS; end
               OP_WRITE_HIT:  begin novo_o = LINHA_M; msg_o = MSG_INVALIDAR; end
               OP_WRITE_MISS: begin novo_o = LINHA_M; msg_o = MSG_WRITE_MISS; end
               default: ;
            endcase
         end
`ifdef COERENCIA_MESI_EN
         LINHA_E: begin
            // exclusive-clean: a write upgrades silently, no bus traffic needed
            case (op_i)
               OP_WRITE_HIT:  novo_o = LINHA_M;
               OP_READ_MISS:  begin novo_o = ler_novo; msg_o = MSG_READ_MISS; end
               OP_WRITE_MISS: begin novo_o = LINHA_M; msg_o = MSG_WRITE_MISS; end
               default: ;
            endcase
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: rtl/coerencia_snoop_n.sv
// Snooping MSI/MESI coherence controller for one private cache; COERENCIA_MESI_EN enables MESI.
// state      | meaning
// OCIOSO     | idle, accepts processor requests, local ops complete here
// ESPERA_BUS | bus message posted, waiting for bus_ack to commit the new line state
module coerencia_snoop_n
   import coerencia_pkg::*;
#(
   parameter  int NUM_LINHAS = 4,
   localparam int IDX_W      = $clog2(NUM_LINHAS)
)(
   input  logic             clock,
   input  logic             resetn,
   input  logic             proc_valid,
   input  logic [1:0]       proc_op,
   input  logic [IDX_W-1:0] proc_idx,
   output logic             proc_ready,
   output logic             proc_done,
   output logic             erro,
   output logic             bus_valid,
   output logic [1:0]       bus_msg,
   output logic [IDX_W-1:0] bus_idx,
   input  logic             bus_ack,
   input  logic             bus_compartilhado,
   input  logic             snoop_valid,
   input  logic [1:0]       snoop_msg,
   input  logic [IDX_W-1:0] snoop_idx,
   output logic             snoop_compartilhado,
   output logic             writeBack,
   input  logic [IDX_W-1:0] consulta_idx,
   output logic [1:0]       consulta_estado
);

   fsm_t             estado_q;
   linha_t           tabela_q [NUM_LINHAS];
   linha_t           tabela_d [NUM_LINHAS];
   logic [IDX_W-1:0] pend_idx_q;
   linha_t           pend_orig_q;
   op_t              pend_op_q;
   logic             bus_valid_q;
   msg_t             bus_msg_q;
   logic [IDX_W-1:0] bus_idx_q;
   logic             proc_done_q;
   logic             erro_q;
   logic             wb_q;

   linha_t te_estado;
   op_t    te_op;
   linha_t te_novo;
   msg_t   te_msg;
   logic   te_wb;
   logic   te_erro;
   logic   aceita;
   logic   commit;
   logic   wb_snoop;
   msg_t   snoop_m;

   assign proc_ready = (estado_q == OCIOSO) && !(snoop_valid && (snoop_idx == proc_idx));
   assign aceita     = proc_valid && proc_ready;
   assign commit     = (estado_q == ESPERA_BUS) && bus_ack;
   assign snoop_m    = msg_t'(snoop_msg);

   // One evaluator serves both phases: request decode when idle, final state at ack
   // (where MESI needs bus_compartilhado) when waiting.
   assign te_estado = (estado_q == ESPERA_BUS) ? pend_orig_q : tabela_q[proc_idx];
   assign te_op     = (estado_q == ESPERA_BUS) ? pend_op_q : op_t'(proc_op);

   transicao_emissor u_transicao (
      .estado_i        (te_estado),
      .op_i            (te_op),
      .compartilhado_i (bus_compartilhado),
      .novo_o          (te_novo),
      .msg_o           (te_msg),
      .wb_o            (te_wb),
      .erro_o          (te_erro)
   );

   always_comb begin
      tabela_d = tabela_q;
      wb_snoop = 1'b0;
      if (snoop_valid) begin
         case (tabela_q[snoop_idx])
            LINHA_M: begin
               if (snoop_m == MSG_READ_MISS) begin
                  tabela_d[snoop_idx] = LINHA_S;
                  wb_snoop            = 1'b1;
               end else if (snoop_m == MSG_WRITE_MISS) begin
                  tabela_d[snoop_idx] = LINHA_I;
                  wb_snoop            = 1'b1;
               end
            end
            LINHA_S: begin
               if (snoop_m == MSG_WRITE_MISS || snoop_m == MSG_INVALIDAR)
                  tabela_d[snoop_idx] = LINHA_I;
            end
            LINHA_E: begin
               if (snoop_m == MSG_READ_MISS)
                  tabela_d[snoop_idx] = LINHA_S;
               else if (snoop_m == MSG_WRITE_MISS || snoop_m == MSG_INVALIDAR)
                  tabela_d[snoop_idx] = LINHA_I;
            end
            default: ;
         endcase
      end
      if (aceita && (te_msg == MSG_SEM))
         tabela_d[proc_idx] = te_novo;
      // commit is applied last so it overrides a same-cycle snoop on the pending line
      if (commit)
         tabela_d[pend_idx_q] = te_novo;
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         estado_q    <= OCIOSO;
         for (int i = 0; i < NUM_LINHAS; i++)
            tabela_q[i] <= LINHA_I;
         pend_idx_q  <= '0;
         pend_orig_q <= LINHA_I;
         pend_op_q   <= OP_READ_HIT;
         bus_valid_q <= 1'b0;
         bus_msg_q   <= MSG_SEM;
         bus_idx_q   <= '0;
         proc_done_q <= 1'b0;
         erro_q      <= 1'b0;
         wb_q        <= 1'b0;
      end else begin
         tabela_q    <= tabela_d;
         proc_done_q <= 1'b0;
         erro_q      <= 1'b0;
         wb_q        <= wb_snoop | (aceita & te_wb);
         case (estado_q)
            OCIOSO: begin
               if (aceita) begin
                  if (te_msg == MSG_SEM) begin
                     proc_done_q <= 1'b1;
                     erro_q      <= te_erro;
                  end else begin
                     estado_q    <= ESPERA_BUS;
                     pend_idx_q  <= proc_idx;
                     pend_orig_q <= tabela_q[proc_idx];
                     pend_op_q   <= op_t'(proc_op);
                     bus_valid_q <= 1'b1;
                     bus_msg_q   <= te_msg;
                     bus_idx_q   <= proc_idx;
                  end
               end
            end
            ESPERA_BUS: begin
               if (bus_ack) begin
                  estado_q    <= OCIOSO;
                  bus_valid_q <= 1'b0;
                  bus_msg_q   <= MSG_SEM;
                  proc_done_q <= 1'b1;
               end
            end
            default: estado_q <= OCIOSO;
         endcase
      end
   end

   assign proc_done           = proc_done_q;
   assign erro                = erro_q;
   assign bus_valid           = bus_valid_q;
   assign bus_msg             = bus_msg_q;
   assign bus_idx             = bus_idx_q;
   assign writeBack           = wb_q;
   assign snoop_compartilhado = snoop_valid && (tabela_q[snoop_idx] != LINHA_I);
   assign consulta_estado     = tabela_q[consulta_idx];

endmodule
